// File: rtl/clk_div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_div_mon_pkg;

  // Shallowest synchronizer that still gives a metastability-safe sample of div_in
  localparam int CLK_DIV_MON_MIN_SYNC = 2;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    STUCK
  } clk_div_mon_state_e;

  // Adds two counts and clamps the result to the largest value a width-bit counter can hold
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] maxVal;
    sum    = {1'b0, a} + {1'b0, b};
    maxVal = (33'd1 << width) - 33'd1;
    return (sum > maxVal) ? maxVal[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/clk_div_monitor_sync_edge_det.sv
// Synchronizer chain for the asynchronous divided clock, followed by a previous-sample
// flop and registered edge strobes; lvl, rise and fall are mutually aligned.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Shift the input through the synchronizer and register edges against the previous sample
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign lvl  = prev_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures high/low/period of div_in in clk cycles, tracks lock
// against exp_period and flags a stuck divider output.
// Optional duty-cycle checker enabled by defining CLK_DIV_MON_DUTY_CHK_EN.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             locked,
  output logic             stuck,
  output logic             stuck_level,
  output logic             duty_err
);

  localparam int SYNC_N = (SYNC_STAGES < CLK_DIV_MON_MIN_SYNC) ? CLK_DIV_MON_MIN_SYNC : SYNC_STAGES;
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);

  logic lvl, rise, fall;

  clk_div_mon_state_e state_q, state_d;
  logic [CNT_W-1:0]   highAcc_q, highAcc_d;
  logic [CNT_W-1:0]   lowAcc_q, lowAcc_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic               stuck_q, stuck_d;
  logic               stuckLevel_q, stuckLevel_d;
  logic               publish;
  logic               enterStuck;

  logic [CNT_W-1:0]   period_q, highCnt_q, lowCnt_q;
  logic               measValid_q;
  logic [LOCK_W-1:0]  lockCnt_q;
  logic               locked_q;

  logic [CNT_W-1:0]   periodSum;
  logic [CNT_W-1:0]   periodDiff;
  logic               periodMatch;
  logic [LOCK_W-1:0]  lockNext;

  sync_edge_det #(
    .STAGES(SYNC_N)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (div_in),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  // Period of the phase just closed and whether it lands inside the lock window
  always_comb begin
    periodSum   = CNT_W'(sat_add(32'(highAcc_q), 32'(lowAcc_q), CNT_W));
    periodDiff  = (periodSum >= exp_period) ? (periodSum - exp_period) : (exp_period - periodSum);
    periodMatch = (32'(periodDiff) <= 32'(TOL));
    lockNext    = '0;
    if (periodMatch) begin
      lockNext = (lockCnt_q == LOCK_MAX) ? LOCK_MAX : (lockCnt_q + LOCK_W'(1));
    end
  end

  // Phase tracking: count high and low time, publish on each rising edge, fall into STUCK on timeout
  always_comb begin
    state_d      = state_q;
    highAcc_d    = highAcc_q;
    lowAcc_d     = lowAcc_q;
    phase_d      = (rise | fall) ? ONE_C : CNT_W'(sat_add(32'(phase_q), 32'd1, CNT_W));
    stuck_d      = stuck_q;
    stuckLevel_d = stuckLevel_q;
    publish      = 1'b0;
    enterStuck   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = HIGH;
          highAcc_d = ONE_C;
        end else if (phase_q >= TIMEOUT_C) begin
          enterStuck = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d  = LOW;
          lowAcc_d = ONE_C;
        end else if (phase_q >= TIMEOUT_C) begin
          enterStuck = 1'b1;
        end else if (lvl) begin
          highAcc_d = CNT_W'(sat_add(32'(highAcc_q), 32'd1, CNT_W));
        end
      end
      LOW: begin
        if (rise) begin
          publish   = 1'b1;
          state_d   = HIGH;
          highAcc_d = ONE_C;
        end else if (phase_q >= TIMEOUT_C) begin
          enterStuck = 1'b1;
        end else if (!lvl) begin
          lowAcc_d = CNT_W'(sat_add(32'(lowAcc_q), 32'd1, CNT_W));
        end
      end
      STUCK: begin
        if (rise | fall) begin
          state_d      = IDLE;
          stuck_d      = 1'b0;
          stuckLevel_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enterStuck) begin
      state_d      = STUCK;
      stuck_d      = 1'b1;
      stuckLevel_d = lvl;
    end
  end

  // State register and phase accumulators
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      highAcc_q    <= '0;
      lowAcc_q     <= '0;
      phase_q      <= '0;
      stuck_q      <= 1'b0;
      stuckLevel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      highAcc_q    <= highAcc_d;
      lowAcc_q     <= lowAcc_d;
      phase_q      <= phase_d;
      stuck_q      <= stuck_d;
      stuckLevel_q <= stuckLevel_d;
    end
  end

  // Published measurement and lock status, refreshed together on each completed period
  always_ff @(posedge clk) begin
    if (reset) begin
      measValid_q <= 1'b0;
      period_q    <= '0;
      highCnt_q   <= '0;
      lowCnt_q    <= '0;
      lockCnt_q   <= '0;
      locked_q    <= 1'b0;
    end else begin
      measValid_q <= publish;
      if (publish) begin
        period_q  <= periodSum;
        highCnt_q <= highAcc_q;
        lowCnt_q  <= lowAcc_q;
        lockCnt_q <= lockNext;
        locked_q  <= (lockNext == LOCK_MAX);
      end else if (enterStuck) begin
        lockCnt_q <= '0;
        locked_q  <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_MON_DUTY_CHK_EN
  logic             dutyErr_q;
  logic [CNT_W-1:0] dutyDiff;

  // Distance between high and low time of the period being published
  always_comb begin
    dutyDiff = (highAcc_q >= lowAcc_q) ? (highAcc_q - lowAcc_q) : (lowAcc_q - highAcc_q);
  end

  // Duty flag follows each measurement and is dropped when the divider stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      dutyErr_q <= 1'b0;
    end else if (publish) begin
      dutyErr_q <= (dutyDiff > ONE_C);
    end else if (enterStuck) begin
      dutyErr_q <= 1'b0;
    end
  end

  assign duty_err = dutyErr_q;
`else
  assign duty_err = 1'b0;
`endif

  assign meas_valid  = measValid_q;
  assign period      = period_q;
  assign high_cnt    = highCnt_q;
  assign low_cnt     = lowCnt_q;
  assign locked      = locked_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuckLevel_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed self-checking bench for clk_div_monitor: three instances share div_in
// (main: TIMEOUT=64 TOL=0, sat: CNT_W=4 TIMEOUT=15, tol: TOL=1).
module tb_clk_div_monitor;

  typedef struct {
    int   cyc;
    int   period;
    int   high;
    int   low;
    logic locked;
    logic duty;
  } pulse_t;

`ifdef CLK_DIV_MON_DUTY_CHK_EN
  localparam logic DUTY_ON = 1'b1;
`else
  localparam logic DUTY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic divIn = 1'b0;
  logic [15:0] expPeriod = 16'd0;
  logic [3:0]  expPeriodSat = 4'd15;
  int cycle = 0;

  logic        mMeasValid, mLocked, mStuck, mStuckLevel, mDutyErr;
  logic [15:0] mPeriod, mHigh, mLow;
  logic        sMeasValid, sLocked, sStuck, sStuckLevel, sDutyErr;
  logic [3:0]  sPeriod, sHigh, sLow;
  logic        tMeasValid, tLocked, tStuck, tStuckLevel, tDutyErr;
  logic [15:0] tPeriod, tHigh, tLow;

  pulse_t mQ[$];
  pulse_t sQ[$];
  pulse_t tQ[$];
  pulse_t mp, sp, tp;

  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  clk_div_monitor #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(64), .LOCK_CNT(4), .TOL(0)) dutMain (
    .clk(clk), .reset(reset), .div_in(divIn), .exp_period(expPeriod),
    .meas_valid(mMeasValid), .period(mPeriod), .high_cnt(mHigh), .low_cnt(mLow),
    .locked(mLocked), .stuck(mStuck), .stuck_level(mStuckLevel), .duty_err(mDutyErr));

  clk_div_monitor #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(15), .LOCK_CNT(4), .TOL(0)) dutSat (
    .clk(clk), .reset(reset), .div_in(divIn), .exp_period(expPeriodSat),
    .meas_valid(sMeasValid), .period(sPeriod), .high_cnt(sHigh), .low_cnt(sLow),
    .locked(sLocked), .stuck(sStuck), .stuck_level(sStuckLevel), .duty_err(sDutyErr));

  clk_div_monitor #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(64), .LOCK_CNT(4), .TOL(1)) dutTol (
    .clk(clk), .reset(reset), .div_in(divIn), .exp_period(expPeriod),
    .meas_valid(tMeasValid), .period(tPeriod), .high_cnt(tHigh), .low_cnt(tLow),
    .locked(tLocked), .stuck(tStuck), .stuck_level(tStuckLevel), .duty_err(tDutyErr));

  // Record every published measurement of each instance
  always @(negedge clk) begin
    if (mMeasValid) begin
      mp.cyc = cycle; mp.period = int'(mPeriod); mp.high = int'(mHigh); mp.low = int'(mLow);
      mp.locked = mLocked; mp.duty = mDutyErr;
      mQ.push_back(mp);
    end
    if (sMeasValid) begin
      sp.cyc = cycle; sp.period = int'(sPeriod); sp.high = int'(sHigh); sp.low = int'(sLow);
      sp.locked = sLocked; sp.duty = sDutyErr;
      sQ.push_back(sp);
    end
    if (tMeasValid) begin
      tp.cyc = cycle; tp.period = int'(tPeriod); tp.high = int'(tHigh); tp.low = int'(tLow);
      tp.locked = tLocked; tp.duty = tDutyErr;
      tQ.push_back(tp);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic pulse_t pick(input pulse_t q[$], input int idx);
    pulse_t p;
    p.cyc = -1; p.period = -1; p.high = -1; p.low = -1; p.locked = 1'bx; p.duty = 1'bx;
    if (idx < q.size()) p = q[idx];
    return p;
  endfunction

  // One divided-clock period starting with a rising edge
  task automatic applyStimulus(input int hi, input int lo);
    divIn = 1'b1;
    repeat (hi) @(negedge clk);
    divIn = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Final rising edge that closes the last period, held long enough to be published
  task automatic trailRise();
    divIn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " meas_valid"}, 32'(mMeasValid), 0);
    checkOutput({tag, " period"}, 32'(mPeriod), 0);
    checkOutput({tag, " high_cnt"}, 32'(mHigh), 0);
    checkOutput({tag, " low_cnt"}, 32'(mLow), 0);
    checkOutput({tag, " locked"}, 32'(mLocked), 0);
    checkOutput({tag, " stuck"}, 32'(mStuck), 0);
    checkOutput({tag, " stuck_level"}, 32'(mStuckLevel), 0);
    checkOutput({tag, " duty_err"}, 32'(mDutyErr), 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    divIn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mQ.delete(); sQ.delete(); tQ.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic waitMeasValid(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mMeasValid) found = 1'b1;
    end
    checkOutput({tag, " meas_valid seen"}, 32'(found), 1);
  endtask

  initial begin
    pulse_t p;
    $display("[TB] start");

    // Reset state: during reset and on the first cycle after release
    repeat (3) @(negedge clk);
    checkAllZero("in reset");
    reset = 1'b0;
    @(negedge clk);
    checkAllZero("after reset");

    // Divide-by-2 lock
    expPeriod = 16'd2;
    resetDut();
    repeat (6) applyStimulus(1, 1);
    trailRise();
    checkOutput("div2 pulse count", 32'(mQ.size()), 6);
    for (int i = 0; i < 6; i++) begin
      p = pick(mQ, i);
      checkOutput($sformatf("div2[%0d] period", i), 32'(p.period), 2);
      checkOutput($sformatf("div2[%0d] high", i), 32'(p.high), 1);
      checkOutput($sformatf("div2[%0d] low", i), 32'(p.low), 1);
      checkOutput($sformatf("div2[%0d] locked", i), 32'(p.locked), (i >= 3) ? 1 : 0);
      if (i > 0) checkOutput($sformatf("div2[%0d] spacing", i), 32'(p.cyc - pick(mQ, i - 1).cyc), 2);
    end

    // Ratio and duty change
    expPeriod = 16'd6;
    resetDut();
    repeat (6) applyStimulus(3, 3);
    applyStimulus(4, 2);
    repeat (2) applyStimulus(4, 4);
    trailRise();
    checkOutput("ratio pulse count", 32'(mQ.size()), 9);
    checkOutput("ratio[0] period", 32'(pick(mQ, 0).period), 6);
    checkOutput("ratio[2] locked", 32'(pick(mQ, 2).locked), 0);
    checkOutput("ratio[3] locked", 32'(pick(mQ, 3).locked), 1);
    checkOutput("ratio[6] period", 32'(pick(mQ, 6).period), 6);
    checkOutput("ratio[6] high", 32'(pick(mQ, 6).high), 4);
    checkOutput("ratio[6] low", 32'(pick(mQ, 6).low), 2);
    checkOutput("ratio[6] duty_err", 32'(pick(mQ, 6).duty), 32'(DUTY_ON));
    checkOutput("ratio[6] locked", 32'(pick(mQ, 6).locked), 1);
    checkOutput("ratio[7] period", 32'(pick(mQ, 7).period), 8);
    checkOutput("ratio[7] locked", 32'(pick(mQ, 7).locked), 0);
    checkOutput("ratio[7] duty_err", 32'(pick(mQ, 7).duty), 0);

    // Stuck detection and recovery
    resetDut();
    repeat (6) applyStimulus(3, 3);
    divIn = 1'b1;
    waitMeasValid("stuck lastedge");
    checkOutput("stuck pre locked", 32'(mLocked), 1);
    repeat (63) @(negedge clk);
    checkOutput("stuck at 63", 32'(mStuck), 0);
    @(negedge clk);
    checkOutput("stuck at 64", 32'(mStuck), 1);
    checkOutput("stuck_level", 32'(mStuckLevel), 1);
    checkOutput("stuck locked", 32'(mLocked), 0);
    mQ.delete();
    divIn = 1'b0;
    repeat (2) @(negedge clk);
    repeat (3) applyStimulus(2, 2);
    trailRise();
    checkOutput("recover stuck", 32'(mStuck), 0);
    checkOutput("recover stuck_level", 32'(mStuckLevel), 0);
    checkOutput("recover pulse count", 32'(mQ.size()), 3);
    checkOutput("recover[0] period", 32'(pick(mQ, 0).period), 4);
    checkOutput("recover[0] locked", 32'(pick(mQ, 0).locked), 0);

    // Reset in the middle of a high phase
    resetDut();
    repeat (2) applyStimulus(3, 3);
    divIn = 1'b1;
    waitMeasValid("midhigh");
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("midhigh reset");
    reset = 1'b0;
    mQ.delete();
    applyStimulus(4, 3);
    trailRise();
    checkOutput("midhigh pulse count", 32'(mQ.size()), 1);
    checkOutput("midhigh[0] period", 32'(pick(mQ, 0).period), 7);
    checkOutput("midhigh[0] high", 32'(pick(mQ, 0).high), 4);
    checkOutput("midhigh[0] low", 32'(pick(mQ, 0).low), 3);

    // Saturation on the narrow instance
    resetDut();
    repeat (2) applyStimulus(10, 10);
    trailRise();
    checkOutput("sat pulse count", 32'(sQ.size()), 2);
    checkOutput("sat[0] period", 32'(pick(sQ, 0).period), 15);
    checkOutput("sat[0] high", 32'(pick(sQ, 0).high), 10);
    checkOutput("sat[0] low", 32'(pick(sQ, 0).low), 10);
    checkOutput("wide[0] period", 32'(pick(mQ, 0).period), 20);

    // Tolerance window
    expPeriod = 16'd6;
    resetDut();
    repeat (2) begin
      applyStimulus(3, 2);
      applyStimulus(3, 4);
      applyStimulus(3, 3);
    end
    applyStimulus(4, 4);
    trailRise();
    checkOutput("tol pulse count", 32'(tQ.size()), 7);
    checkOutput("tol[0] period", 32'(pick(tQ, 0).period), 5);
    checkOutput("tol[1] period", 32'(pick(tQ, 1).period), 7);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("tol[%0d] locked", i), 32'(pick(tQ, i).locked), (i >= 3 && i <= 5) ? 1 : 0);
    end
    checkOutput("tol0[5] locked", 32'(pick(mQ, 5).locked), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Receive-side checker for divided clocks produced by the team's clock-divider blocks (e.g. the divide-by-2). It samples a divided-clock signal `div_in` in the `clk` domain and measures its high time, low time and period in `clk` cycles. It flags lock against an expected period and flags a stuck (non-toggling) divider output. It sits beside any divider as a built-in self-check and drives status and debug registers.

## Interface
- `CNT_W`, 16: width of the high, low and period counters.
- `SYNC_STAGES`, 2: synchronizer depth on `div_in`; minimum 2.
- `TIMEOUT`, 1000: number of cycles without an edge before `stuck` is declared; must be ≤ 2^CNT_W−1.
- `LOCK_CNT`, 4: number of consecutive in-tolerance periods needed to assert `locked`.
- `TOL`, 0: allowed ± deviation of the measured period from `exp_period`.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `div_in`  in  1  divided clock under test; treated as asynchronous.
- `exp_period`  in  CNT_W  expected period in `clk` cycles; sampled at each measurement.
- `meas_valid`  out  1  one-cycle pulse when a full period has been measured.
- `period`  out  CNT_W  last measured period, held between pulses.
- `high_cnt`  out  CNT_W  high time of the last measured period.
- `low_cnt`  out  CNT_W  low time of the last measured period.
- `locked`  out  1  set after LOCK_CNT consecutive matching periods.
- `stuck`  out  1  no edge seen for TIMEOUT cycles.
- `stuck_level`  out  1  synchronized level of `div_in` while `stuck` is set.
- `duty_err`  out  1  duty-cycle violation on the last period (see Configuration).

## Operation
- Input path: SYNC_STAGES flops, then a previous-sample flop.
  - Rising edge: synced value is 1 and previous sample is 0. Falling edge is the reverse.
  - Reset clears the chain to 0. A `div_in` held at 1 through reset therefore yields one rising edge after reset.
- States: IDLE, HIGH, LOW, STUCK.
  - IDLE (reset state): on the first rising edge go to HIGH with `high_acc`=1. Nothing is reported.
  - HIGH: `high_acc`++ while the synced value is 1. On a falling edge go to LOW with `low_acc`=1.
  - LOW: `low_acc`++ while the synced value is 0. On a rising edge, publish `high_cnt`=`high_acc`, `low_cnt`=`low_acc` and `period`=`high_acc`+`low_acc`, pulse `meas_valid`, then go to HIGH with `high_acc`=1.
  - Timeout: in IDLE, HIGH or LOW, if the current phase count (cycles since the last edge) reaches TIMEOUT, go to STUCK. Set `stuck`=1, set `stuck_level` to the synced value, clear `locked` and the lock counter.
  - STUCK: any edge clears `stuck` and goes to IDLE. The next full rising-to-rising period is the first one reported.
- Arithmetic: accumulators and the `period` sum saturate at 2^CNT_W−1 and never wrap.
- Lock:
  - On each `meas_valid`, `period` counts as a match if |`period`−`exp_period`| ≤ TOL.
  - A match increments the lock counter, saturating at LOCK_CNT. `locked`=1 when the counter equals LOCK_CNT.
  - A mismatch zeroes the counter and clears `locked` in the same update.
  - A change of `exp_period` takes effect at the next measurement.
- Reset mid-operation: the partial period is discarded and no `meas_valid` is produced for it.

## Timing
- All outputs are 0 during reset and on the first cycle after `reset` deasserts.
- Latency: a `div_in` rising edge captured at clk edge k gives `meas_valid` high after clk edge k+SYNC_STAGES+1. `period`, `high_cnt`, `low_cnt`, `locked` and `duty_err` update on that same edge.
- Minimum measurable period is 2, i.e. `div_in` toggling every `clk` cycle, as a divide-by-2 does.
- `stuck` rises on the edge at which the phase count reaches TIMEOUT. It falls one cycle after the clearing edge is detected.

## Configuration
- `CLK_DIV_MON_DUTY_CHK_EN` defined: on each `meas_valid`, `duty_err` = (|`high_cnt`−`low_cnt`| > 1). The value holds until the next measurement and is cleared on entry to STUCK.
- Not defined: `duty_err` is tied to 0 and no comparator is built.

## Structure
- Package `clk_div_mon_pkg`:
  - state enum typedef (IDLE, HIGH, LOW, STUCK);
  - saturating-add helper function;
  - `CLK_DIV_MON_MIN_SYNC`=2 localparam.
- Sub-module `sync_edge_det`: SYNC_STAGES-flop synchronizer plus previous-sample flop. Outputs `lvl`, `rise` and `fall`; takes synchronous `reset`.

## Test plan
- **Divide-by-2 lock:** `div_in` toggling every cycle, `exp_period`=2, LOCK_CNT=4 → `meas_valid` every 2 cycles with `period`=2, `high_cnt`=1, `low_cnt`=1; `locked`=1 with the 4th pulse.
- **Ratio and duty change:** 3-high/3-low, `exp_period`=6, until locked; then switch to 4-high/2-low → first new pulse gives `period`=6, `high_cnt`=4, `low_cnt`=2, `duty_err`=1 (macro on) or 0 (off), and `locked` stays 1. Then switch to 4-high/4-low → `period`=8 and `locked`=0 on that pulse.
- **Stuck detection:** TIMEOUT=64, hold `div_in`=1 → `stuck`=1, `stuck_level`=1, `locked`=0 exactly 64 cycles after the last detected edge. Resume toggling → `stuck` clears; no `meas_valid` until the second rising edge after recovery.
- **Reset mid-HIGH:** assert `reset` for 1 cycle during HIGH after 5 counted cycles → all outputs 0 the next cycle; no `meas_valid` for the interrupted period.
- **Saturation:** CNT_W=4, TIMEOUT=15, 10-high/10-low → `period`=15, `high_cnt`=10, `low_cnt`=10.
- **Tolerance:** TOL=1, `exp_period`=6, periods cycling 5, 7, 6 → `locked` set after LOCK_CNT pulses and never dropped; then a period of 8 → `locked`=0.
